// File: rtl/hilo_divider.sv
// hilo_divider: iterative restoring divider for DIV/DIVU feeding the HI/LO registers.
// The quotient goes to LO, the remainder goes to HI, and done drives both write enables.
// Latency is fixed at DATA_WIDTH+2 cycles from the accept edge, divide-by-zero included.
// Optional build macro HILO_DIVIDER_ZERO_FLAG_EN adds the div_by_zero output.
module hilo_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  is_signed,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
`ifdef HILO_DIVIDER_ZERO_FLAG_EN
   ,
   output logic                  div_by_zero
`endif
);

   localparam int CW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  state;
   logic [CW-1:0]           count;
   logic [DATA_WIDTH-1:0]   part_rem;   // partial remainder
   logic [DATA_WIDTH-1:0]   work_q;     // dividend magnitude shifting out, quotient bits shifting in
   logic [DATA_WIDTH-1:0]   dsr_mag;    // divisor magnitude
   logic                    quo_neg;
   logic                    rem_neg;
   logic                    dsr_zero;

   logic [DATA_WIDTH:0]     shifted;
   logic [DATA_WIDTH-1:0]   trial;
   logic                    fits;
   logic [DATA_WIDTH-1:0]   dvd_abs;
   logic [DATA_WIDTH-1:0]   dsr_abs;
   logic [DATA_WIDTH-1:0]   q_fix;
   logic [DATA_WIDTH-1:0]   r_fix;

   // Operand magnitudes, one restoring step, and sign correction of the final result.
   always_comb begin
      // NOTE: every signal gets a value on every path, so no latch is inferred.
      shifted = {part_rem, work_q[DATA_WIDTH-1]};
      fits    = (shifted >= {1'b0, dsr_mag});
      // When fits is set the true difference is below dsr_mag, so the low bits are exact.
      trial   = shifted[DATA_WIDTH-1:0] - dsr_mag;
      dvd_abs = (is_signed && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
      dsr_abs = (is_signed && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;
      // Negating a zero remainder yields zero, so a clean remainder is never made negative.
      r_fix   = rem_neg ? -part_rem : part_rem;
      if (dsr_zero)
         q_fix = '1;
      else if (quo_neg)
         q_fix = -work_q;
      else
         q_fix = work_q;
   end

   // Control FSM with datapath registers and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
      if (reset) begin
         // NOTE: working registers are cleared too, so an aborted operation leaves no stale state.
         state     <= IDLE;
         count     <= '0;
         part_rem  <= '0;
         work_q    <= '0;
         dsr_mag   <= '0;
         quo_neg   <= 1'b0;
         rem_neg   <= 1'b0;
         dsr_zero  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef HILO_DIVIDER_ZERO_FLAG_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  part_rem <= '0;
                  work_q   <= dvd_abs;
                  dsr_mag  <= dsr_abs;
                  quo_neg  <= is_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                  rem_neg  <= is_signed & dividend[DATA_WIDTH-1];
                  dsr_zero <= (divisor == '0);
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= CALC;
`ifdef HILO_DIVIDER_ZERO_FLAG_EN
                  div_by_zero <= (divisor == '0);
`endif
               end
            end
            CALC: begin
               if (count == CW'(DATA_WIDTH)) begin
                  quotient  <= q_fix;
                  remainder <= r_fix;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  part_rem <= fits ? trial : shifted[DATA_WIDTH-1:0];
                  work_q   <= {work_q[DATA_WIDTH-2:0], fits};
                  count    <= count + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider: self-checking bench for hilo_divider.
// A cycle-level behavioural model (arithmetic division plus a cycle count from the accept edge)
// is compared against the DUT on every falling edge; directed and random operations add
// end-of-operation checks, some against hand-computed literals.
module tb_hilo_divider;

   localparam int W       = 32;
   localparam int DONE_AT = W + 1;   // edge index after accept that raises done
   localparam int IDLE_AT = W + 2;   // edge index that returns to idle

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          is_signed;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          busy;
   logic          done;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
`ifdef HILO_DIVIDER_ZERO_FLAG_EN
   logic          div_by_zero;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   hilo_divider #(.DATA_WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef HILO_DIVIDER_ZERO_FLAG_EN
      ,
      .div_by_zero (div_by_zero)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Reference arithmetic: {quotient, remainder} from the architectural DIV/DIVU rules.
   function automatic logic [63:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   // Cycle-level model: count edges since the accept edge and publish results at DONE_AT.
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   int           m_cnt  = 0;
   logic [63:0]  m_pend = '0;
   logic [31:0]  m_q    = '0;
   logic [31:0]  m_r    = '0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_cnt  <= 0;
         m_q    <= '0;
         m_r    <= '0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy <= 1'b1;
            m_cnt  <= 1;
            m_pend <= model_div(is_signed, dividend, divisor);
         end
      end else begin
         m_cnt <= m_cnt + 1;
         if (m_cnt == DONE_AT) begin
            m_q    <= m_pend[63:32];
            m_r    <= m_pend[31:0];
            m_done <= 1'b1;
         end
         if (m_cnt == IDLE_AT) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
         end
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge clock) begin
      check("cyc busy",      {63'd0, busy}, {63'd0, m_busy});
      check("cyc done",      {63'd0, done}, {63'd0, m_done});
      check("cyc quotient",  {32'd0, quotient},  {32'd0, m_q});
      check("cyc remainder", {32'd0, remainder}, {32'd0, m_r});
   end

   // One operation: start for a single cycle, watch 40 cycles, then check timing and held results.
   task automatic do_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input bit use_lit, input logic [31:0] lit_q, input logic [31:0] lit_r,
                        input int inject);
      logic [63:0] exp;
      int          done_cyc;
      int          pulses;
`ifdef HILO_DIVIDER_ZERO_FLAG_EN
      logic        dz_seen;
      dz_seen = 1'b0;
`endif
      exp       = model_div(s, a, b);
      start     = 1'b1;
      is_signed = s;
      dividend  = a;
      divisor   = b;
      @(negedge clock);
      start     = 1'b0;
      is_signed = 1'($urandom);
      dividend  = $urandom;
      divisor   = $urandom;
      done_cyc  = 0;
      pulses    = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 1)  check({name, " busy at cycle 1"},  {63'd0, busy}, 64'd1);
         if (c == 35) check({name, " busy at cycle 35"}, {63'd0, busy}, 64'd0);
         if (done) begin
            pulses++;
            if (done_cyc == 0) done_cyc = c;
`ifdef HILO_DIVIDER_ZERO_FLAG_EN
            dz_seen = div_by_zero;
`endif
         end
         if (c == inject) begin
            start     = 1'b1;
            is_signed = 1'b0;
            dividend  = 32'd9;
            divisor   = 32'd3;
         end else begin
            start = 1'b0;
         end
         if (c < 40) @(negedge clock);
      end
      check({name, " done cycle"},  64'(done_cyc), 64'd34);
      check({name, " done pulses"}, 64'(pulses),   64'd1);
      check({name, " quotient"},    {32'd0, quotient},  {32'd0, exp[63:32]});
      check({name, " remainder"},   {32'd0, remainder}, {32'd0, exp[31:0]});
      if (use_lit) begin
         check({name, " quotient literal"},  {32'd0, quotient},  {32'd0, lit_q});
         check({name, " remainder literal"}, {32'd0, remainder}, {32'd0, lit_r});
      end
`ifdef HILO_DIVIDER_ZERO_FLAG_EN
      check({name, " div_by_zero"}, {63'd0, dz_seen}, {63'd0, (b == 32'd0)});
`endif
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;

      // Pin the reference arithmetic with hand-computed values.
      check("model 100/7",        model_div(1'b0, 32'd100, 32'd7),             {32'd14, 32'd2});
      check("model -7/2",         model_div(1'b1, 32'hFFFF_FFF9, 32'd2),       {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      check("model 7/-2",         model_div(1'b1, 32'd7, 32'hFFFF_FFFE),       {32'hFFFF_FFFD, 32'd1});
      check("model sovf",         model_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h8000_0000, 32'd0});
      check("model u 8000/FFFF",  model_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF), {32'd0, 32'h8000_0000});
      check("model signed /0",    model_div(1'b1, 32'hFFFF_FFF9, 32'd0),       {32'hFFFF_FFFF, 32'hFFFF_FFF9});

      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset busy",      {63'd0, busy}, 64'd0);
      check("reset done",      {63'd0, done}, 64'd0);
      check("reset quotient",  {32'd0, quotient},  64'd0);
      check("reset remainder", {32'd0, remainder}, 64'd0);
      reset = 1'b0;
      @(negedge clock);

      do_op("u 100/7",   1'b0, 32'd100,        32'd7,           1, 32'd14,        32'd2,         0);
      do_op("s -7/2",    1'b1, 32'hFFFF_FFF9,  32'd2,           1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
      do_op("s 7/-2",    1'b1, 32'd7,          32'hFFFF_FFFE,   1, 32'hFFFF_FFFD, 32'd1,         0);
      do_op("s ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,   1, 32'h8000_0000, 32'd0,         0);
      do_op("u 8000/FF", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,   1, 32'd0,         32'h8000_0000, 0);
      do_op("u /0",      1'b0, 32'h0000_1234,  32'd0,           1, 32'hFFFF_FFFF, 32'h0000_1234, 0);
      do_op("u 8/2",     1'b0, 32'd8,          32'd2,           1, 32'd4,         32'd0,         0);
      do_op("ignore",    1'b0, 32'hFFFF_FFFF,  32'd1,           1, 32'hFFFF_FFFF, 32'd0,         5);

      // Reset in the middle of an operation clears outputs without waiting for a clock edge.
      start     = 1'b1;
      is_signed = 1'b0;
      dividend  = 32'd1000;
      divisor   = 32'd10;
      @(negedge clock);
      start = 1'b0;
      repeat (9) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("async busy",      {63'd0, busy}, 64'd0);
      check("async done",      {63'd0, done}, 64'd0);
      check("async quotient",  {32'd0, quotient},  64'd0);
      check("async remainder", {32'd0, remainder}, 64'd0);
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      do_op("u 50/5", 1'b0, 32'd50, 32'd5, 1, 32'd10, 32'd0, 0);

      for (int i = 0; i < 20; i++) begin
         logic        s;
         logic [31:0] a;
         logic [31:0] b;
         s = 1'($urandom_range(0, 1));
         a = pick();
         b = pick();
         do_op("rand", s, a, b, 0, 32'd0, 32'd0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
